// File: rtl/inst_rom_port.sv
// -----------------------------------------------------------------------------
// inst_rom_port
//
// Instruction memory with a valid/ready request port and a valid/ready
// response port. It handles one fetch at a time. The read latency is
// configurable. Misaligned and out-of-range fetches are reported on rsp_err.
// They never alias into the array.
//
// Optional macro: IMEM_FLUSH_EN adds a 'flush' input. Flush abandons a fetch
// that is waiting or held. Reset has priority over flush.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active low
//   req_valid  in   fetch request present
//   req_ready  out  block can accept a request this cycle (combinational)
//   req_addr   in   byte address of fetch
//   rsp_valid  out  response word valid
//   rsp_ready  in   consumer accepts response
//   flush      in   (IMEM_FLUSH_EN only) abandon the outstanding fetch
//   rsp_inst   out  fetched instruction, byte order per BYTE_SWAP
//   rsp_addr   out  echo of the accepted req_addr
//   rsp_err    out  bit0 = misaligned, bit1 = out of range
// -----------------------------------------------------------------------------
module inst_rom_port #(
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter int          BYTE_SWAP = 1,
    parameter              INIT_FILE = "",
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
`ifdef IMEM_FLUSH_EN
    input  logic              flush,
`endif
    output logic [31:0]       rsp_inst,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_err
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [1:0]          err_reg;
    logic [ADDR_W-1:0]   rsp_addr_reg;
    logic [1:0]          rsp_err_reg;
    logic                inst_nop_reg;
    logic [31:0]         rd_word_reg;
    logic [31:0]         out_word;

    logic                flush_w;
    logic                accept;
    logic [1:0]          req_err;
    logic                load_rsp;
    logic [ADDR_W-1:0]   ld_addr;
    logic [1:0]          ld_err;
    logic [IDX_W-1:0]    ld_idx;

    logic [31:0]         mem [DEPTH];

`ifdef IMEM_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // HOLD can take a new request on the same edge its response is consumed.
    assign req_ready = !flush_w &&
                       ((state_reg == IDLE) || ((state_reg == HOLD) && rsp_ready));
    assign accept    = req_valid && req_ready;

    assign req_err[0] = (req_addr[1:0] != 2'b00);
    assign req_err[1] = ({1'b0, req_addr >> 2} >= DEPTH_L);

    // With a single-cycle latency, HOLD is entered on the accept edge itself.
    // The response is then loaded straight from the request. Otherwise it is
    // loaded from the latched copy when WAIT expires.
    assign load_rsp = (LATENCY == 1) ? accept
                                     : ((state_reg == WAIT) && (cnt_reg == 4'd1) && !flush_w);
    assign ld_addr  = (LATENCY == 1) ? req_addr : addr_reg;
    assign ld_err   = (LATENCY == 1) ? req_err  : err_reg;
    assign ld_idx   = ld_addr[IDX_W+1:2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (flush_w) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
        end else if (accept) begin
            state_next = (LATENCY > 1) ? WAIT : HOLD;
            cnt_next   = CNT_LOAD;
        end else begin
            case (state_reg)
                WAIT: begin
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        state_next = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            err_reg      <= 2'b00;
            rsp_addr_reg <= '0;
            rsp_err_reg  <= 2'b00;
            inst_nop_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= req_addr;
                err_reg  <= req_err;
            end
            if (load_rsp) begin
                rsp_addr_reg <= ld_addr;
                rsp_err_reg  <= ld_err;
                inst_nop_reg <= (ld_err != 2'b00);
            end
        end
    end

    // Registered array read. It has no reset, so it maps onto block RAM.
    // A faulting fetch never touches the array. inst_nop_reg substitutes
    // NOP_INST instead.
    always_ff @(posedge clk) begin
        if (load_rsp && (ld_err == 2'b00)) begin
            rd_word_reg <= mem[ld_idx];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            if (BYTE_SWAP != 0) begin : g_swap
                assign out_word[8*gi +: 8] = rd_word_reg[8*(3-gi) +: 8];
            end else begin : g_pass
                assign out_word[8*gi +: 8] = rd_word_reg[8*gi +: 8];
            end
        end
    endgenerate

    assign rsp_valid = (state_reg == HOLD);
    assign rsp_inst  = inst_nop_reg ? NOP_INST : out_word;
    assign rsp_addr  = rsp_addr_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_inst_rom_port.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_port
//
// Three instances share one stimulus stream:
//   idx 0: LATENCY=2, BYTE_SWAP=1
//   idx 1: LATENCY=1, BYTE_SWAP=0
//   idx 2: LATENCY=3, BYTE_SWAP=1
// A transaction-level model tracks each one as "busy, valid from edge E".
// It is checked against every output on every falling edge once reset has
// been applied. Directed literal checks pin the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_inst_rom_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, rsp_ready;
    logic [31:0] req_addr;
    logic        fl_s;
`ifdef IMEM_FLUSH_EN
    logic        flush;
    assign fl_s = flush;
`else
    assign fl_s = 1'b0;
`endif

    logic        rdy [3];
    logic        vld [3];
    logic [31:0] inst [3];
    logic [31:0] addr [3];
    logic [1:0]  err [3];

    inst_rom_port #(.LATENCY(2), .BYTE_SWAP(1)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_addr(req_addr), .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
`ifdef IMEM_FLUSH_EN
        .flush(flush),
`endif
        .rsp_inst(inst[0]), .rsp_addr(addr[0]), .rsp_err(err[0]));

    inst_rom_port #(.LATENCY(1), .BYTE_SWAP(0)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_addr(req_addr), .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
`ifdef IMEM_FLUSH_EN
        .flush(flush),
`endif
        .rsp_inst(inst[1]), .rsp_addr(addr[1]), .rsp_err(err[1]));

    inst_rom_port #(.LATENCY(3), .BYTE_SWAP(1)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_addr(req_addr), .rsp_valid(vld[2]), .rsp_ready(rsp_ready),
`ifdef IMEM_FLUSH_EN
        .flush(flush),
`endif
        .rsp_inst(inst[2]), .rsp_addr(addr[2]), .rsp_err(err[2]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference image and model ----------------
    logic [31:0] img [1024];
    int          lat_k [3] = '{2, 1, 3};
    bit          swp_k [3] = '{1'b1, 1'b0, 1'b1};

    function automatic logic [1:0] model_err(input logic [31:0] a);
        return {((a >> 2) >= 32'd1024), (a[1:0] != 2'b00)};
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] a, input bit swp);
        logic [31:0] w;
        if (model_err(a) != 2'b00) return NOP;
        w = img[a[11:2]];
        return swp ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    endfunction

    int          ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    bit          live = 1'b0;
    bit          m_busy [3];
    int          m_vf   [3];
    logic [31:0] p_inst [3], p_addr [3], o_inst [3], o_addr [3];
    logic [1:0]  p_err  [3], o_err  [3];

    always @(negedge clk) begin : model_proc
        logic ev, er;
        for (int k = 0; k < 3; k++) begin
            ev = m_busy[k] && (ecount >= m_vf[k]);
            er = !fl_s && (!m_busy[k] || (ev && rsp_ready));
            if (live) begin
                chk($sformatf("m%0d_rsp_valid", k), vld[k], ev);
                chk($sformatf("m%0d_req_ready", k), rdy[k], er);
                chk($sformatf("m%0d_rsp_inst", k), inst[k], o_inst[k]);
                chk($sformatf("m%0d_rsp_addr", k), addr[k], o_addr[k]);
                chk($sformatf("m%0d_rsp_err", k), err[k], o_err[k]);
            end
            // Predict the effect of the coming rising edge.
            if (!rst) begin
                m_busy[k] = 1'b0;
                o_inst[k] = NOP;
                o_addr[k] = 32'h0;
                o_err[k]  = 2'b00;
            end else if (fl_s) begin
                m_busy[k] = 1'b0;
            end else begin
                if (ev && rsp_ready) m_busy[k] = 1'b0;
                if (req_valid && er) begin
                    m_busy[k] = 1'b1;
                    m_vf[k]   = ecount + lat_k[k];
                    p_inst[k] = model_inst(req_addr, swp_k[k]);
                    p_addr[k] = req_addr;
                    p_err[k]  = model_err(req_addr);
                end
                if (m_busy[k] && (m_vf[k] == ecount + 1)) begin
                    o_inst[k] = p_inst[k];
                    o_addr[k] = p_addr[k];
                    o_err[k]  = p_err[k];
                end
            end
        end
        if (!rst) live = 1'b1;
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] err_addrs [3] = '{32'h6, 32'h1000, 32'h1002};
    logic [1:0]  err_exp   [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] mix_addrs [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h6, 32'h1000, 32'h10, 32'h1002};

    initial begin
        for (int i = 0; i < 1024; i++) img[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
        img[0] = 32'hDEAD_BEEF;
        img[1] = 32'h1234_5678;
        img[2] = 32'hCAFE_F00D;
        for (int i = 0; i < 1024; i++) begin
            u_l2.mem[i] = img[i];
            u_l1.mem[i] = img[i];
            u_l3.mem[i] = img[i];
        end

        rst = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
`ifdef IMEM_FLUSH_EN
        flush = 1'b0;
`endif
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_valid", vld[0], 1'b0);
        chk("reset_inst", inst[0], NOP);
        chk("reset_addr", addr[0], 32'h0);
        chk("reset_err", err[0], 2'b00);
        chk("reset_ready", rdy[0], 1'b1);

        // Accept 0x4, then apply backpressure.
        step(); req_valid = 1'b1; req_addr = 32'h4;
        step(); req_valid = 1'b0;                      // edge N done
        @(negedge clk);
        chk("t1_wait_ready", rdy[0], 1'b0);
        chk("t1_wait_valid", vld[0], 1'b0);
        chk("t1_l1_valid", vld[1], 1'b1);
        chk("t1_l1_inst", inst[1], 32'h1234_5678);
        step();                                        // edge N+1
        @(negedge clk);
        chk("t1_valid", vld[0], 1'b1);
        chk("t1_inst", inst[0], 32'h7856_3412);
        chk("t1_addr", addr[0], 32'h4);
        chk("t1_err", err[0], 2'b00);
        repeat (5) step();
        @(negedge clk);
        chk("bp_inst", inst[0], 32'h7856_3412);
        chk("bp_ready", rdy[0], 1'b0);
        chk("bp_valid", vld[0], 1'b1);
        step(); rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_release_valid", vld[0], 1'b0);
        chk("bp_release_ready", rdy[0], 1'b1);

        // Back-to-back fetches through the single-cycle instance.
        step(); req_valid = 1'b1; req_addr = 32'h0;
        step(); req_addr = 32'h4;
        @(negedge clk);
        chk("t2_v0", vld[1], 1'b1); chk("t2_a0", addr[1], 32'h0); chk("t2_i0", inst[1], 32'hDEAD_BEEF);
        step(); req_addr = 32'h8;
        @(negedge clk);
        chk("t2_v1", vld[1], 1'b1); chk("t2_a1", addr[1], 32'h4); chk("t2_i1", inst[1], 32'h1234_5678);
        step(); req_valid = 1'b0;
        @(negedge clk);
        chk("t2_v2", vld[1], 1'b1); chk("t2_a2", addr[1], 32'h8); chk("t2_i2", inst[1], 32'hCAFE_F00D);
        repeat (4) step();

        // Faulting addresses.
        for (int i = 0; i < 3; i++) begin
            step(); req_valid = 1'b1; req_addr = err_addrs[i];
            step(); req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t3_err_%0d", i), err[1], err_exp[i]);
            chk($sformatf("t3_inst_%0d", i), inst[1], NOP);
            chk($sformatf("t3_addr_%0d", i), addr[1], err_addrs[i]);
            repeat (4) step();
        end

        // Reset while the LATENCY=3 instance is waiting.
        step(); req_valid = 1'b1; req_addr = 32'h8;
        step(); req_valid = 1'b0; rst = 1'b0;          // edge N done
        step(); rst = 1'b1;                            // edge N+1 reset
        @(negedge clk);
        chk("t4_ready", rdy[2], 1'b1);
        chk("t4_valid", vld[2], 1'b0);
        chk("t4_inst", inst[2], NOP);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("t4_valid_%0d", i), vld[2], 1'b0);
        end

        // Mixed traffic with intermittent backpressure; the model checks it.
        for (int c = 0; c < 40; c++) begin
            step();
            req_valid = ((c % 3) != 2);
            req_addr  = mix_addrs[c % 8];
            rsp_ready = ((c % 5) != 1);
        end
        step(); req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) step();

`ifdef IMEM_FLUSH_EN
        step(); req_valid = 1'b1; req_addr = 32'h0;
        step(); req_valid = 1'b0; flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk);
        chk("t6_valid", vld[2], 1'b0);
        chk("t6_ready", rdy[2], 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("t6_valid_%0d", i), vld[2], 1'b0);
        end
        step(); req_valid = 1'b1; req_addr = 32'h4;
        step(); req_valid = 1'b0;                      // edge M done
        step(); step();                                // edges M+1, M+2
        @(negedge clk);
        chk("t6_next_valid", vld[2], 1'b1);
        chk("t6_next_inst", inst[2], 32'h7856_3412);
        repeat (3) step();
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
